// File: rtl/dsp48_mac_pkg.sv
// Widths, Z-select codes and pre-adder op codes shared by the DSP48-style MAC wrapper.
package dsp48_mac_pkg;

    localparam int A_W = 25;
    localparam int B_W = 18;
    localparam int M_W = A_W + B_W;
    localparam int P_W = 48;
    localparam int ZSH = 17;

    // Z operand select, taken from mode[4:2]; unlisted codes select zero
    localparam logic [2:0] ZSEL_ZERO    = 3'b000;
    localparam logic [2:0] ZSEL_PCIN    = 3'b001;
    localparam logic [2:0] ZSEL_P       = 3'b010;
    localparam logic [2:0] ZSEL_C       = 3'b011;
    localparam logic [2:0] ZSEL_PCIN_SH = 3'b101;
    localparam logic [2:0] ZSEL_P_SH    = 3'b110;

    // Pre-adder op, taken from mode[1:0]
    localparam logic [1:0] PRE_A_PLUS_D  = 2'b00;
    localparam logic [1:0] PRE_D_MINUS_A = 2'b01;
    localparam logic [1:0] PRE_A_ONLY    = 2'b10;
    localparam logic [1:0] PRE_ZERO      = 2'b11;

    function automatic logic [P_W-1:0] ash17(input logic [P_W-1:0] v);
        return {{ZSH{v[P_W-1]}}, v[P_W-1:ZSH]};
    endfunction

endpackage

// File: rtl/dsp48_mac_preadd.sv
// A/D input register stages plus the registered pre-adder (AD) stage.
// The pre-adder op travels through the same stages as A so it stays aligned.
module dsp48_mac_preadd
    import dsp48_mac_pkg::*;
#(
    parameter int    AREG      = 1,
    parameter string USE_DPORT = "TRUE"
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ce1,
    input  logic                  ce2,
    input  logic signed [A_W-1:0] a,
    input  logic signed [A_W-1:0] d,
    input  logic [1:0]            op,
    output logic signed [A_W-1:0] ad
);

    logic signed [A_W-1:0] a1_q, a1_d, a2_q, a2_d;
    logic signed [A_W-1:0] d1_q, d1_d, d2_q, d2_d;
    logic [1:0]            op1_q, op1_d, op2_q, op2_d;
    logic signed [A_W-1:0] ad_q, ad_d;
    logic signed [A_W-1:0] a_s, d_s;
    logic [1:0]            op_s;

    always_comb begin
        a1_d  = ce1 ? a  : a1_q;
        d1_d  = ce1 ? d  : d1_q;
        op1_d = ce1 ? op : op1_q;
        a2_d  = ce2 ? a1_q  : a2_q;
        d2_d  = ce2 ? d1_q  : d2_q;
        op2_d = ce2 ? op1_q : op2_q;

        a_s  = (AREG == 2) ? a2_q  : a1_q;
        d_s  = (AREG == 2) ? d2_q  : d1_q;
        op_s = (AREG == 2) ? op2_q : op1_q;

        // Results are 25 bits wide; the carry out is deliberately dropped
        ad_d = ad_q;
        if (ce2) begin
            if (USE_DPORT == "FALSE") begin
                ad_d = a_s;
            end else begin
                case (op_s)
                    PRE_A_PLUS_D:  ad_d = a_s + d_s;
                    PRE_D_MINUS_A: ad_d = d_s - a_s;
                    PRE_A_ONLY:    ad_d = a_s;
                    default:       ad_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a1_q  <= '0;
            a2_q  <= '0;
            d1_q  <= '0;
            d2_q  <= '0;
            op1_q <= '0;
            op2_q <= '0;
            ad_q  <= '0;
        end else begin
            a1_q  <= a1_d;
            a2_q  <= a2_d;
            d1_q  <= d1_d;
            d2_q  <= d2_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
            ad_q  <= ad_d;
        end
    end

    assign ad = ad_q;

endmodule

// File: rtl/dsp48_mac_wrap.sv
// DSP48E1-style MAC: pre-adder, 25x18 multiply, 48-bit Z-selectable accumulator, scaled output.
// Define DSP48_MAC_WRAP_OVF_EN to add the registered signed-overflow flag output ovf.
module dsp48_mac_wrap
    import dsp48_mac_pkg::*;
#(
    parameter int    S         = 18,
    parameter int    AREG      = 1,
    parameter int    BREG      = 2,
    parameter string USE_DPORT = "TRUE"
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ce1,
    input  logic                  ce2,
    input  logic                  cem,
    input  logic                  cep,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    input  logic signed [P_W-1:0] c,
    input  logic signed [A_W-1:0] d,
    input  logic [4:0]            mode,
    input  logic signed [P_W-1:0] pcin,
    output logic signed [P_W-1:0] pcout,
`ifdef DSP48_MAC_WRAP_OVF_EN
    output logic                  ovf,
`endif
    output logic [P_W-S-1:0]      p
);

    logic signed [A_W-1:0] ad;
    logic signed [B_W-1:0] b1_q, b1_d, b2_q, b2_d, b_s;
    logic signed [M_W-1:0] m_q, m_d;
    logic signed [P_W-1:0] c_q, c_d;
    logic [2:0]            zsel_q, zsel_d;
    logic signed [P_W-1:0] p_q, p_d;
    logic signed [P_W-1:0] m_ext, z, sum;

    dsp48_mac_preadd #(
        .AREG      (AREG),
        .USE_DPORT (USE_DPORT)
    ) u_preadd (
        .clock (clock),
        .reset (reset),
        .ce1   (ce1),
        .ce2   (ce2),
        .a     (a),
        .d     (d),
        .op    (mode[1:0]),
        .ad    (ad)
    );

    always_comb begin
        b1_d = ce1 ? b    : b1_q;
        b2_d = ce2 ? b1_q : b2_q;
        b_s  = (BREG == 2) ? b2_q : b1_q;

        // Operands widened first so the full 43-bit signed product is kept
        m_d = cem ? (M_W'(ad) * M_W'(b_s)) : m_q;

        c_d    = cep ? c : c_q;
        zsel_d = cep ? mode[4:2] : zsel_q;

        m_ext = P_W'(m_q);
        case (zsel_q)
            ZSEL_PCIN:    z = pcin;
            ZSEL_P:       z = p_q;
            ZSEL_C:       z = c_q;
            ZSEL_PCIN_SH: z = ash17(pcin);
            ZSEL_P_SH:    z = ash17(p_q);
            default:      z = '0;
        endcase
        sum = m_ext + z;
        p_d = cep ? sum : p_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            b1_q   <= '0;
            b2_q   <= '0;
            m_q    <= '0;
            c_q    <= '0;
            zsel_q <= ZSEL_ZERO;
            p_q    <= '0;
        end else begin
            b1_q   <= b1_d;
            b2_q   <= b2_d;
            m_q    <= m_d;
            c_q    <= c_d;
            zsel_q <= zsel_d;
            p_q    <= p_d;
        end
    end

`ifdef DSP48_MAC_WRAP_OVF_EN
    logic ovf_q, ovf_d, add_ovf;

    // Signed overflow: operands share a sign that the wrapped sum does not
    always_comb begin
        add_ovf = (m_ext[P_W-1] == z[P_W-1]) && (sum[P_W-1] != m_ext[P_W-1]);
        ovf_d   = cep ? add_ovf : ovf_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign pcout = p_q;
    assign p     = p_q[P_W-1:S];

endmodule

// File: tb/tb_dsp48_mac_wrap.sv
// Self-checking bench for dsp48_mac_wrap: directed scenarios plus a randomized run
// against a latency-based arithmetic reference model.
module tb_dsp48_mac_wrap;

    logic        clock;
    logic        reset;
    logic        ce1, ce2, cem, cep;
    logic [24:0] a, d;
    logic [17:0] b;
    logic [47:0] c, pcin;
    logic [4:0]  mode;
    logic [47:0] pcout;
    logic [29:0] p;
`ifdef DSP48_MAC_WRAP_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: products in flight, and the P / C / Z-select registers
    longint m_hist[$];
    longint exp_p;
    longint c_r;
    logic [2:0] zsel_r;
    bit     exp_ovf;

    dsp48_mac_wrap u_dut (
        .clock (clock),
        .reset (reset),
        .ce1   (ce1),
        .ce2   (ce2),
        .cem   (cem),
        .cep   (cep),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .mode  (mode),
        .pcin  (pcin),
        .pcout (pcout),
`ifdef DSP48_MAC_WRAP_OVF_EN
        .ovf   (ovf),
`endif
        .p     (p)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic longint sx(input longint v, input int w);
        longint t;
        t = v << (64 - w);
        return t >>> (64 - w);
    endfunction

    function automatic longint ref_product(input logic [24:0] av, input logic [24:0] dv,
                                           input logic [17:0] bv, input logic [1:0] op);
        longint sa, sd, pre;
        sa = sx(longint'(av), 25);
        sd = sx(longint'(dv), 25);
        case (op)
            2'd0:    pre = sa + sd;
            2'd1:    pre = sd - sa;
            2'd2:    pre = sa;
            default: pre = 0;
        endcase
        pre = sx(pre, 25);
        return pre * sx(longint'(bv), 18);
    endfunction

    // Inputs seen at edge n reach P at edge n+3; mode/c reach P one edge after capture.
    function automatic void model_edge();
        longint m_use, z, full;
        if (reset) begin
            m_hist.delete();
            for (int i = 0; i < 3; i++) m_hist.push_back(0);
            exp_p   = 0;
            c_r     = 0;
            zsel_r  = 3'b000;
            exp_ovf = 1'b0;
        end else begin
            m_use = m_hist.pop_front();
            m_hist.push_back(ref_product(a, d, b, mode[1:0]));
            case (zsel_r)
                3'b001:  z = sx(longint'(pcin), 48);
                3'b010:  z = exp_p;
                3'b011:  z = c_r;
                3'b101:  z = sx(longint'(pcin), 48) >>> 17;
                3'b110:  z = exp_p >>> 17;
                default: z = 0;
            endcase
            full = m_use + z;
            if (cep) begin
                exp_p   = sx(full, 48);
                exp_ovf = (full > 64'sd140737488355327) || (full < -64'sd140737488355328);
                zsel_r  = mode[4:2];
                c_r     = sx(longint'(c), 48);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_inputs(input int av, input int dv, input int bv, input longint cv,
                              input logic [4:0] mv);
        a    = 25'(av);
        d    = 25'(dv);
        b    = 18'(bv);
        c    = 48'(cv);
        mode = mv;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        ce1 = 1'b1; ce2 = 1'b1; cem = 1'b1; cep = 1'b1;
        pcin = 48'h1234_5678_9ABC;
        set_inputs(64000, 32000, 4096, 131072, 5'b01100);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (p !== 30'd0 || pcout !== 48'd0)
                $display("FAIL reset_clear cycle %0d: p=%0d pcout=%0d, want 0/0", i, p, pcout);
            else n_pass++;
        end
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (i < 4) begin
                if (p !== 30'd0)
                    $display("FAIL reset_latency edge %0d: p=%0d want 0", i, p);
                else n_pass++;
            end else begin
                if (p !== 30'd1500 || pcout !== 48'd393347072)
                    $display("FAIL round_load: p=%0d pcout=%0d want 1500/393347072", p, pcout);
                else n_pass++;
            end
        end
    endtask

    task automatic test_accumulate();
        int want[4] = '{1500, 3000, 4500, 6000};
        mode = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (p !== 30'(want[i]))
                $display("FAIL accumulate step %0d: p=%0d want %0d", i, p, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_cep_hold();
        cep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (p !== 30'd6000 || pcout !== 48'd1572995072)
                $display("FAIL cep_hold cycle %0d: p=%0d pcout=%0d want 6000/1572995072", i, p, pcout);
            else n_pass++;
        end
        cep = 1'b1;
        tick();
        n_checks++;
        if (p !== 30'd7500) $display("FAIL cep_resume1: p=%0d want 7500", p);
        else n_pass++;
        tick();
        n_checks++;
        if (p !== 30'd9000) $display("FAIL cep_resume2: p=%0d want 9000", p);
        else n_pass++;
    endtask

    task automatic test_neg_round();
        logic signed [47:0] want_pc;
        want_pc = -48'sd262012928;
        reset = 1'b1;
        tick();
        set_inputs(-64000, 0, 4096, 131072, 5'b01100);
        reset = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (p !== 30'h3FFFFC18 || pcout !== want_pc)
            $display("FAIL neg_round: p=%0h pcout=%0h want 3ffffc18/%0h", p, pcout, want_pc);
        else n_pass++;
    endtask

    task automatic test_latency();
        set_inputs(0, 0, 0, 0, 5'b00000);
        do_reset();
        set_inputs(64, 0, 1, 0, 5'b01100);
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 1) set_inputs(0, 0, 0, 0, 5'b00000);
            n_checks++;
            if (pcout !== ((e == 4) ? 48'd64 : 48'd0))
                $display("FAIL latency edge %0d: pcout=%0d want %0d", e, pcout, (e == 4) ? 64 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_preadd_ops();
        int av[6]  = '{1000, 1000, 1000, 1000, 16777215, -5};
        int dv[6]  = '{300, 300, 300, 300, 1, -2};
        int bv[6]  = '{7, 7, 7, 7, 3, -131072};
        int opv[6] = '{0, 1, 2, 3, 0, 1};
        longint want[6];
        want[0] = (1000 + 300) * 7;
        want[1] = (300 - 1000) * 7;
        want[2] = 1000 * 7;
        want[3] = 0;
        want[4] = -16777216 * 3;
        want[5] = (-2 - -5) * -131072;
        for (int k = 0; k < 6; k++) begin
            set_inputs(av[k], dv[k], bv[k], 0, {3'b000, 2'(opv[k])});
            repeat (4) tick();
            n_checks++;
            if (pcout !== want[k][47:0])
                $display("FAIL preadd case %0d: pcout=%0d want %0d", k, $signed(pcout), want[k]);
            else n_pass++;
        end
    endtask

    task automatic test_ce_pipe();
        for (int k = 0; k < 3; k++) begin
            ce1 = 1'b1; ce2 = 1'b1; cem = 1'b1; cep = 1'b1;
            set_inputs(64000, 32000, 4096, 131072, 5'b01100);
            do_reset();
            repeat (5) tick();
            n_checks++;
            if (p !== 30'd1500) $display("FAIL ce_pipe%0d_load: p=%0d want 1500", k, p);
            else n_pass++;
            case (k)
                0:       ce1 = 1'b0;
                1:       ce2 = 1'b0;
                default: cem = 1'b0;
            endcase
            set_inputs(-64000, 0, 4096, 131072, 5'b01100);
            for (int i = 0; i < 4; i++) begin
                tick();
                n_checks++;
                if (p !== 30'd1500) $display("FAIL ce_pipe%0d_hold cycle %0d: p=%0d want 1500", k, i, p);
                else n_pass++;
            end
            ce1 = 1'b1; ce2 = 1'b1; cem = 1'b1;
            repeat (5) tick();
            n_checks++;
            if (p !== 30'h3FFFFC18) $display("FAIL ce_pipe%0d_resume: p=%0h want 3ffffc18", k, p);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        ce1 = 1'b1; ce2 = 1'b1; cem = 1'b1; cep = 1'b1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a    = 25'($urandom);
            d    = 25'($urandom);
            b    = 18'($urandom);
            c    = {16'($urandom), $urandom};
            pcin = {16'($urandom), $urandom};
            mode = 5'($urandom);
            cep  = ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (pcout !== exp_p[47:0] || p !== exp_p[47:18])
                $display("FAIL random cycle %0d: pcout=%0h p=%0h want %0h/%0h",
                         i, pcout, p, exp_p[47:0], exp_p[47:18]);
            else n_pass++;
`ifdef DSP48_MAC_WRAP_OVF_EN
            n_checks++;
            if (ovf !== exp_ovf)
                $display("FAIL random_ovf cycle %0d: ovf=%0b want %0b", i, ovf, exp_ovf);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        reset = 1'b1;
        ce1 = 1'b1; ce2 = 1'b1; cem = 1'b1; cep = 1'b1;
        a = '0; b = '0; c = '0; d = '0; mode = '0; pcin = '0;
        for (int i = 0; i < 3; i++) m_hist.push_back(0);
        exp_p = 0; c_r = 0; zsel_r = 3'b000; exp_ovf = 1'b0;

        test_reset();
        test_accumulate();
        test_cep_hold();
        test_neg_round();
        test_latency();
        test_preadd_ops();
        test_ce_pipe();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
